tone_gen: RTL and testbench

TONE_GEN -- requirements
Module: tone_gen

---
 rtl/tone_pkg.sv | 13 +
 rtl/tone_env.sv | 72 +++++++
 rtl/tone_gen.sv | 131 +++++++++++++
 tb/tb_tone_gen.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared state encoding and constants for the tone generator slice.
package tone_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        DECAY = 2'd2
    } tone_state_t;

    localparam int LEVEL_W    = 4;
    localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/tone_env.sv
// Amplitude envelope: level follows volume while a key is held; with
// TONE_GEN_DECAY_EN defined it steps down one unit every DECAY_STEP cycles after release.
module tone_env
    import tone_pkg::*;
`ifdef TONE_GEN_DECAY_EN
#(
    parameter int DECAY_STEP = 1000000
)
`endif
(
    input  logic               clk,
    input  logic               rst,
`ifdef TONE_GEN_DECAY_EN
    input  tone_state_t        state,
`endif
    input  tone_state_t        next_state,
    input  logic [LEVEL_W-1:0] volume,
`ifdef TONE_GEN_DECAY_EN
    output logic               level_zero,
`endif
    output logic [LEVEL_W-1:0] level
);

`ifdef TONE_GEN_DECAY_EN
    logic [31:0] decay_cnt;
    logic        decay_tick;

    assign decay_tick = (decay_cnt == 32'(DECAY_STEP - 1));

    // Looks one edge ahead so the voice goes idle on the same edge the level reaches zero.
    assign level_zero = (level == '0) || ((level == LEVEL_W'(1)) && decay_tick);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level     <= '0;
            decay_cnt <= '0;
        end else begin
            case (next_state)
                PLAY: begin
                    level     <= volume;
                    decay_cnt <= '0;
                end
                DECAY: begin
                    if (state != DECAY) begin
                        decay_cnt <= '0;
                    end else if (decay_tick) begin
                        decay_cnt <= '0;
                        if (level != '0)
                            level <= level - LEVEL_W'(1);
                    end else begin
                        decay_cnt <= decay_cnt + 32'd1;
                    end
                end
                default: begin
                    level     <= '0;
                    decay_cnt <= '0;
                end
            endcase
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            level <= '0;
        else if (next_state == PLAY)
            level <= volume;
        else
            level <= '0;
    end
`endif

endmodule

// File: rtl/tone_gen.sv
// Square-wave tone generator with PWM volume; optional release envelope under
// TONE_GEN_DECAY_EN (undefined by default: release is immediate).
module tone_gen
    import tone_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int DECAY_STEP = 1000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CNT_W-1:0]   half_period,
    input  logic               gate,
    input  logic [LEVEL_W-1:0] volume,
    output logic               phase,
    output logic               audio,
    output logic               busy
);

    if (CNT_W < 2) begin : g_bad_cnt_w
        $error("tone_gen: CNT_W must be at least 2");
    end
    if (DECAY_STEP < 1) begin : g_bad_step
        $error("tone_gen: DECAY_STEP must be at least 1");
    end

    tone_state_t        state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [CNT_W-1:0]   period_r, period_nxt;
    logic               phase_nxt;
    logic [LEVEL_W-1:0] level;
    logic [LEVEL_W-1:0] pwm_cnt;
    logic               period_ok;
    logic               wrap;
`ifdef TONE_GEN_DECAY_EN
    logic               level_zero;
`endif

    assign period_ok = (half_period >= CNT_W'(MIN_PERIOD));
    assign wrap      = (cnt == period_r - CNT_W'(1));

    // Pitch changes take effect only at a half-wave boundary so the wave never glitches.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        period_nxt = period_r;
        phase_nxt  = phase;
        case (state)
            IDLE: begin
                if (gate && period_ok) begin
                    state_nxt  = PLAY;
                    cnt_nxt    = '0;
                    period_nxt = half_period;
                    phase_nxt  = 1'b1;
                end
            end
            default: begin
                if (wrap) begin
                    cnt_nxt    = '0;
                    phase_nxt  = ~phase;
                    period_nxt = half_period;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
`ifdef TONE_GEN_DECAY_EN
                if (state == PLAY) begin
                    if (!gate)
                        state_nxt = DECAY;
                end else if (gate) begin
                    state_nxt = PLAY;
                end else if (level_zero) begin
                    state_nxt = IDLE;
                end
`else
                if (!gate)
                    state_nxt = IDLE;
`endif
                if (wrap && !period_ok)
                    state_nxt = IDLE;
            end
        endcase
        if (state_nxt == IDLE) begin
            cnt_nxt    = '0;
            period_nxt = '0;
            phase_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            period_r <= '0;
            phase    <= 1'b0;
            pwm_cnt  <= '0;
            audio    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            period_r <= period_nxt;
            phase    <= phase_nxt;
            pwm_cnt  <= pwm_cnt + LEVEL_W'(1);
            audio    <= phase & (pwm_cnt < level);
            busy     <= (state_nxt != IDLE);
        end
    end

    // The envelope sees the upcoming state so a new note starts at full volume immediately.
`ifdef TONE_GEN_DECAY_EN
    tone_env #(
        .DECAY_STEP (DECAY_STEP)
    ) u_env (
        .clk        (clk),
        .rst        (rst),
        .state      (state),
        .next_state (state_nxt),
        .volume     (volume),
        .level_zero (level_zero),
        .level      (level)
    );
`else
    tone_env u_env (
        .clk        (clk),
        .rst        (rst),
        .next_state (state_nxt),
        .volume     (volume),
        .level      (level)
    );
`endif

endmodule

// File: tb/tb_tone_gen.sv
// Scoreboard bench for tone_gen: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them against phase/audio/busy.
module tb_tone_gen;

    logic        clk;
    logic        rst;
    logic [31:0] half_period;
    logic        gate;
    logic [3:0]  volume;
    logic        phase;
    logic        audio;
    logic        busy;

    tone_gen #(
        .CNT_W      (32),
        .DECAY_STEP (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .half_period (half_period),
        .gate        (gate),
        .volume      (volume),
        .phase       (phase),
        .audio       (audio),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected-value bits are {phase, audio, busy}; mask selects which are checked.
    typedef struct {
        int         cyc;
        logic [2:0] mask;
        logic [2:0] val;
    } exp_t;

    localparam logic [2:0] M_ALL = 3'b111;
    localparam logic [2:0] M_PB  = 3'b101;
    localparam logic [2:0] M_AB  = 3'b011;
    localparam logic [2:0] M_B   = 3'b001;

    exp_t  exp_q[$];
    string name_q[$];
    int    cyc = 0;
    int    rel_cyc = 0;
    int    tests = 0;
    int    fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] pwm_at(input int e);
        return 4'((e - rel_cyc) % 16);
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic g, input logic [31:0] hp, input logic [3:0] vol);
        gate        = g;
        half_period = hp;
        volume      = vol;
    endtask

    task automatic push_exp(input int at, input logic [2:0] mask, input logic [2:0] val, input string name);
        exp_t e;
        int   i;
        e.cyc  = at;
        e.mask = mask;
        e.val  = val;
        i = exp_q.size();
        while (i > 0 && exp_q[i-1].cyc > at) i--;
        exp_q.insert(i, e);
        name_q.insert(i, name);
    endtask

    task automatic checkOutput(input exp_t e, input string name);
        logic [2:0] act;
        act = {phase, audio, busy};
        tests++;
        if ((act & e.mask) !== (e.val & e.mask)) begin
            fails++;
            $display("[TB] FAIL %s @cycle %0d: phase/audio/busy got %b, want %b (mask %b)",
                     name, e.cyc, act, e.val, e.mask);
        end
    endtask

    // Monitor: consumes every expectation due at this cycle.
    always @(negedge clk) begin
        exp_t  cur;
        string cur_name;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            cur      = exp_q.pop_front();
            cur_name = name_q.pop_front();
            if (cur.cyc < cyc) begin
                tests++;
                fails++;
                $display("[TB] FAIL %s: expectation for cycle %0d missed (now %0d)", cur_name, cur.cyc, cyc);
            end else begin
                checkOutput(cur, cur_name);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base, m, p, x, q, s, t;
        string leftover;
        exp_t  lo;

        rst = 1'b1;
        applyStimulus(1'b0, 32'd4, 4'd15);
        tick(2);
        push_exp(cyc, M_ALL, 3'b000, "reset_state");
        tick(1);
        rst = 1'b0;
        rel_cyc = cyc;
        tick(1);

        // Basic tone, half_period 4
        base = cyc;
        applyStimulus(1'b1, 32'd4, 4'd15);
        push_exp(base + 1, M_ALL, 3'b101, "start");
        push_exp(base + 2, M_ALL, {1'b1, pwm_at(base + 1) < 4'd15, 1'b1}, "play_audio1");
        push_exp(base + 3, M_ALL, {1'b1, pwm_at(base + 2) < 4'd15, 1'b1}, "play_audio2");
        push_exp(base + 4, M_PB, 3'b101, "half1_end");
        push_exp(base + 5, M_PB, 3'b001, "toggle1");
        push_exp(base + 6, M_ALL, 3'b001, "low_half_audio");
        push_exp(base + 8, M_PB, 3'b001, "half2_end");
        push_exp(base + 9, M_PB, 3'b101, "toggle2");

        // Pitch change mid half-wave (cnt=1) is deferred to the boundary
        wait_cyc(base + 10);
        applyStimulus(1'b1, 32'd6, 4'd15);
        push_exp(base + 12, M_PB, 3'b101, "defer_old_half");
        push_exp(base + 13, M_PB, 3'b001, "defer_toggle");
        push_exp(base + 18, M_PB, 3'b001, "new_half_hold");
        push_exp(base + 19, M_PB, 3'b101, "new_half_toggle");
        push_exp(base + 24, M_PB, 3'b101, "new_half2_hold");
        push_exp(base + 25, M_PB, 3'b001, "new_half2_toggle");

        // Volume 0 mutes audio while still playing
        wait_cyc(base + 26);
        m = cyc;
        applyStimulus(1'b1, 32'd6, 4'd0);
        push_exp(m + 2, M_AB, 3'b001, "mute1");
        push_exp(m + 5, M_AB, 3'b001, "mute2");
        push_exp(m + 9, M_AB, 3'b001, "mute3");
        wait_cyc(m + 10);
        applyStimulus(1'b0, 32'd6, 4'd0);
`ifdef TONE_GEN_DECAY_EN
        push_exp(m + 11, M_B, 3'b001, "mute_release_decay");
        push_exp(m + 12, M_ALL, 3'b000, "mute_release_idle");
`else
        push_exp(m + 11, M_ALL, 3'b000, "mute_release_idle");
`endif

        // PWM duty: volume 4 gives audio high when pwm_cnt < 4
        wait_cyc(m + 14);
        p = cyc;
        applyStimulus(1'b1, 32'd64, 4'd4);
        push_exp(p + 1, M_ALL, 3'b101, "pwm_start");
        for (int k = 2; k <= 17; k++)
            push_exp(p + k, M_ALL, {1'b1, pwm_at(p + k - 1) < 4'd4, 1'b1}, "pwm_duty");

        // Asynchronous reset mid half-wave, then restart with gate held
        wait_cyc(p + 20);
        rst = 1'b1;
        push_exp(cyc, M_ALL, 3'b000, "async_reset");
        tick(1);
        rst = 1'b0;
        rel_cyc = cyc;
        push_exp(cyc, M_ALL, 3'b000, "reset_held");
        push_exp(cyc + 1, M_ALL, 3'b101, "restart");
        push_exp(cyc + 2, M_ALL, {1'b1, pwm_at(cyc + 1) < 4'd4, 1'b1}, "restart_audio1");
        push_exp(cyc + 3, M_ALL, {1'b1, pwm_at(cyc + 2) < 4'd4, 1'b1}, "restart_audio2");

        // Invalid periods 0 and 1 never start a tone
        wait_cyc(p + 26);
        rst = 1'b1;
        tick(1);
        applyStimulus(1'b1, 32'd0, 4'd4);
        rst = 1'b0;
        x = cyc;
        rel_cyc = x;
        for (int k = 1; k <= 100; k++)
            push_exp(x + k, M_ALL, 3'b000, "hp0_idle");
        wait_cyc(x + 100);
        applyStimulus(1'b1, 32'd1, 4'd4);
        for (int k = 1; k <= 5; k++)
            push_exp(x + 100 + k, M_ALL, 3'b000, "hp1_idle");

        // New period on the start edge is used; invalid period at a toggle stops
        wait_cyc(x + 106);
        q = cyc;
        applyStimulus(1'b1, 32'd3, 4'd4);
        push_exp(q + 1, M_ALL, 3'b101, "start_hp3");
        wait_cyc(q + 1);
        applyStimulus(1'b1, 32'd0, 4'd4);
        push_exp(q + 2, M_PB, 3'b101, "bad_deferred");
        push_exp(q + 3, M_PB, 3'b101, "hp3_hold");
        push_exp(q + 4, M_PB, 3'b000, "bad_at_toggle");
        push_exp(q + 5, M_ALL, 3'b000, "bad_idle");

        // Minimum valid period 2
        wait_cyc(q + 6);
        s = cyc;
        applyStimulus(1'b1, 32'd2, 4'd4);
        push_exp(s + 1, M_PB, 3'b101, "min_start");
        push_exp(s + 2, M_PB, 3'b101, "min_hold");
        push_exp(s + 3, M_PB, 3'b001, "min_toggle1");
        push_exp(s + 5, M_PB, 3'b101, "min_toggle2");

        // Release with volume 3
        wait_cyc(s + 6);
        t = cyc;
        applyStimulus(1'b1, 32'd2, 4'd3);
        wait_cyc(t + 2);
        applyStimulus(1'b0, 32'd2, 4'd3);
        push_exp(t + 2, M_B, 3'b001, "pre_release");
`ifdef TONE_GEN_DECAY_EN
        push_exp(t + 3, M_B, 3'b001, "decay_enter");
        push_exp(t + 14, M_B, 3'b001, "decay_last");
        push_exp(t + 15, M_PB, 3'b000, "decay_done");
        push_exp(t + 16, M_ALL, 3'b000, "decay_idle");
`else
        push_exp(t + 3, M_PB, 3'b000, "release_idle");
        push_exp(t + 4, M_ALL, 3'b000, "release_quiet");
`endif

        wait_cyc(t + 20);
        while (exp_q.size() > 0) begin
            lo       = exp_q.pop_front();
            leftover = name_q.pop_front();
            tests++;
            fails++;
            $display("[TB] FAIL %s: expectation for cycle %0d never checked", leftover, lo.cyc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
